counter_seq: RTL and testbench

//  Run-control sequencer sitting directly upstream of the 6-bit loadable counter.

---
 rtl/counter_pkg.sv | 15 +
 rtl/counter_seq.sv | 108 ++++++++++
 tb/tb_counter_seq.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the counter run-control sequencer and its bench.
package counter_pkg;

  // Width of Data/Count/ReqStart/ReqLimit; must match the downstream counter.
  localparam int COUNT_WIDTH = 6;

  // Sequencer states: preset the counter, let it run, report completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } counter_seq_state_t;

endpackage

// File: rtl/counter_seq.sv
// Run-control sequencer for a loadable up-counter.
// Accepts one {start, limit} job per handshake, presets the counter, lets it
// run until Count reaches limit, then pulses Done for one cycle. Pause freezes
// the count while running; Abort drops the job without a Done pulse.
module counter_seq
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNT_WIDTH
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic [WIDTH-1:0] ReqStart,
  input  logic [WIDTH-1:0] ReqLimit,
  input  logic             Pause,
  input  logic             Abort,
  input  logic [WIDTH-1:0] Count,
  output logic             Load,
  output logic             Enable,
  output logic [WIDTH-1:0] Data,
  output logic             Busy,
  output logic             Done
);

  counter_seq_state_t state;
  logic [WIDTH-1:0]   start_reg;
  logic [WIDTH-1:0]   limit_reg;
  logic               at_limit;

  // Count is only meaningful while the counter is running under our control.
  assign at_limit = (Count == limit_reg);

  // Job FSM with captured start/limit; Abort outranks the limit match.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      start_reg <= '0;
      limit_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ReqValid) begin
            start_reg <= ReqStart;
            limit_reg <= ReqLimit;
            state     <= LOAD;
          end else begin
            state     <= IDLE;
          end
        end
        LOAD: begin
          state <= Abort ? IDLE : RUN;
        end
        RUN: begin
          if (Abort) begin
            state <= IDLE;
          end else if (at_limit) begin
            state <= DONE;
          end else begin
            state <= RUN;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode from the state register; Enable must see Count and Pause
  // in the same cycle so the counter stops exactly on limit.
  always_comb begin
    ReqReady = 1'b0;
    Load     = 1'b0;
    Enable   = 1'b0;
    Busy     = 1'b1;
    Done     = 1'b0;
    Data     = start_reg;
    case (state)
      IDLE: begin
        ReqReady = 1'b1;
        Busy     = 1'b0;
      end
      LOAD: begin
        Load   = 1'b1;
        Enable = 1'b1;
      end
      RUN: begin
        if (at_limit) begin
          Enable = 1'b0;
        end else begin
          Enable = ~Pause;
        end
      end
      DONE: begin
        Done = 1'b1;
      end
      default: begin
        ReqReady = 1'b0;
        Busy     = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_counter_seq.sv
// Directed bench: counter_seq driving a behavioural 6-bit loadable counter
// whose Count is looped back into the sequencer.
module tb_counter_seq;
  import counter_pkg::*;

  localparam int W = COUNT_WIDTH;

  logic         Clock;
  logic         Reset;
  logic         ReqValid;
  logic         ReqReady;
  logic [W-1:0] ReqStart;
  logic [W-1:0] ReqLimit;
  logic         Pause;
  logic         Abort;
  logic [W-1:0] Count;
  logic         Load;
  logic         Enable;
  logic [W-1:0] Data;
  logic         Busy;
  logic         Done;

  int n_vec;
  int n_err;

  counter_seq #(.WIDTH(W)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .ReqStart (ReqStart),
    .ReqLimit (ReqLimit),
    .Pause    (Pause),
    .Abort    (Abort),
    .Count    (Count),
    .Load     (Load),
    .Enable   (Enable),
    .Data     (Data),
    .Busy     (Busy),
    .Done     (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Behavioural loadable counter: Load beats Enable, wraps naturally.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) Count <= '0;
    else if (Load) Count <= Data;
    else if (Enable) Count <= Count + 6'd1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Accept a job and check every cycle up to the Done pulse (no Pause/Abort).
  task automatic do_job(input logic [W-1:0] s, input logic [W-1:0] l, input int n);
    ReqStart = s;
    ReqLimit = l;
    ReqValid = 1'b1;
    check_val("ready_idle", {31'd0, ReqReady}, 32'd1);
    tick();
    ReqValid = 1'b0;
    check_val("load_pulse", {31'd0, Load}, 32'd1);
    check_val("load_data", {26'd0, Data}, {26'd0, s});
    check_val("load_ready", {31'd0, ReqReady}, 32'd0);
    check_val("load_state", {30'd0, dut.state}, {30'd0, LOAD});
    for (int k = 0; k <= n; k++) begin
      tick();
      check_val("run_count", {26'd0, Count}, 32'((s + k) % 64));
      check_val("run_enable", {31'd0, Enable}, (k != n) ? 32'd1 : 32'd0);
      check_val("run_load", {31'd0, Load}, 32'd0);
      check_val("run_nodone", {31'd0, Done}, 32'd0);
    end
    tick();
    check_val("done_pulse", {31'd0, Done}, 32'd1);
    check_val("done_enable", {31'd0, Enable}, 32'd0);
    check_val("done_ready", {31'd0, ReqReady}, 32'd0);
    tick();
    check_val("post_done", {31'd0, Done}, 32'd0);
    check_val("post_busy", {31'd0, Busy}, 32'd0);
    check_val("post_ready", {31'd0, ReqReady}, 32'd1);
    check_val("post_count", {26'd0, Count}, {26'd0, l});
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    Reset    = 1'b1;
    ReqValid = 1'b0;
    ReqStart = '0;
    ReqLimit = '0;
    Pause    = 1'b0;
    Abort    = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    check_val("rst_ready", {31'd0, ReqReady}, 32'd1);
    check_val("rst_busy", {31'd0, Busy}, 32'd0);
    check_val("rst_data", {26'd0, Data}, 32'd0);

    // Test 2: 3 -> 5
    do_job(6'd3, 6'd5, 2);
    // Test 3: 62 -> 1 with wrap
    do_job(6'd62, 6'd1, 3);
    // Test 4: start == limit
    do_job(6'd9, 6'd9, 0);

    // Test 5: 0 -> 4, Pause three cycles at Count=2, then Pause on the match
    ReqStart = 6'd0;
    ReqLimit = 6'd4;
    ReqValid = 1'b1;
    tick();
    ReqValid = 1'b0;
    tick();
    tick();
    tick();
    check_val("p_count2", {26'd0, Count}, 32'd2);
    for (int p = 0; p < 3; p++) begin
      Pause = 1'b1;
      #1;
      check_val("p_enable", {31'd0, Enable}, 32'd0);
      tick();
      check_val("p_hold", {26'd0, Count}, 32'd2);
    end
    Pause = 1'b0;
    #1;
    check_val("p_resume", {31'd0, Enable}, 32'd1);
    tick();
    check_val("p_count3", {26'd0, Count}, 32'd3);
    tick();
    check_val("p_count4", {26'd0, Count}, 32'd4);
    Pause = 1'b1;
    tick();
    check_val("p_match_done", {31'd0, Done}, 32'd1);
    Pause = 1'b0;
    tick();
    check_val("p_idle", {31'd0, Busy}, 32'd0);

    // Test 6: Abort on the edge that brings Count to 2 (limit 10)
    ReqStart = 6'd0;
    ReqLimit = 6'd10;
    ReqValid = 1'b1;
    tick();
    ReqValid = 1'b0;
    tick();
    tick();
    check_val("a_count1", {26'd0, Count}, 32'd1);
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check_val("a_idle", {30'd0, dut.state}, {30'd0, IDLE});
    check_val("a_count2", {26'd0, Count}, 32'd2);
    check_val("a_nodone", {31'd0, Done}, 32'd0);
    check_val("a_ready", {31'd0, ReqReady}, 32'd1);
    tick();
    check_val("a_still2", {26'd0, Count}, 32'd2);
    check_val("a_nodone2", {31'd0, Done}, 32'd0);

    // Abort is ignored in IDLE: job still accepted with Abort high
    ReqStart = 6'd20;
    ReqLimit = 6'd21;
    ReqValid = 1'b1;
    Abort    = 1'b1;
    tick();
    ReqValid = 1'b0;
    Abort    = 1'b0;
    check_val("ai_load", {31'd0, Load}, 32'd1);
    tick();
    tick();
    tick();
    check_val("ai_done", {31'd0, Done}, 32'd1);
    tick();

    // Abort beats the limit match in RUN
    ReqStart = 6'd7;
    ReqLimit = 6'd7;
    ReqValid = 1'b1;
    tick();
    ReqValid = 1'b0;
    tick();
    Abort = 1'b1;
    tick();
    Abort = 1'b0;
    check_val("ab_nodone", {31'd0, Done}, 32'd0);
    check_val("ab_idle", {31'd0, Busy}, 32'd0);

    // New job after abort
    do_job(6'd5, 6'd7, 2);

    // Test 1: Reset mid-cycle during a running job
    ReqStart = 6'd10;
    ReqLimit = 6'd30;
    ReqValid = 1'b1;
    tick();
    ReqValid = 1'b0;
    tick();
    tick();
    #2;
    Reset = 1'b1;
    #1;
    check_val("mr_ready", {31'd0, ReqReady}, 32'd1);
    check_val("mr_load", {31'd0, Load}, 32'd0);
    check_val("mr_enable", {31'd0, Enable}, 32'd0);
    check_val("mr_data", {26'd0, Data}, 32'd0);
    check_val("mr_busy", {31'd0, Busy}, 32'd0);
    check_val("mr_done", {31'd0, Done}, 32'd0);
    tick();
    Reset = 1'b0;
    tick();
    check_val("mr_after", {30'd0, dut.state}, {30'd0, IDLE});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
